dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DEPTH, default 26, number of 32-bit words in the shared data memory.
REQ-002 Parameter DW, default 32, data width.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req0 / req1  input  1  access request from port 0 (CPU MEM stage) / port 1 (loader/debug).
REQ-006 we0 / we1  input  1  1 = write, 0 = read, per port.
REQ-007 addr0 / addr1  input  32  byte address; word index = addr[31:2].
REQ-008 wdata0 / wdata1  input  DW  write data per port.
REQ-009 ack0 / ack1  output  1  one-cycle completion pulse per port.
REQ-010 err0 / err1  output  1  error flag, valid only while the matching ack is high.
REQ-011 rdata0 / rdata1  output  DW  read data, valid only while the matching ack is high.
REQ-012 busy  output  1  high whenever the FSM is not IDLE.
REQ-013 mem_we  output  1  write strobe to the data memory.
REQ-014 mem_addr  output  32  byte address to the data memory.
REQ-015 mem_wdata  output  DW  write data to the data memory.
REQ-016 mem_rdata  input  DW  combinational read data from the data memory at mem_addr.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCESS and RESP.
- IDLE -> ACCESS when any reqN = 1; otherwise stay in IDLE.
- ACCESS -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-018 In IDLE, on a request, the arbiter SHALL register the winner's port id, we, addr and wdata; later input changes do not affect the in-flight access.
REQ-019 Arbitration SHALL be round-robin using a 1-bit last-grant pointer.
- Single requester wins outright.
- When both request, the port not equal to last wins.
- last updates to the winner on every grant.
REQ-020 In ACCESS, mem_addr / mem_wdata SHALL carry the latched values, and mem_we SHALL equal latched we AND the access is valid; mem_rdata is captured into an internal register.
REQ-021 Outside ACCESS, mem_we SHALL be 0, and mem_addr / mem_wdata SHALL be 0.
REQ-022 An access is invalid if addr[1:0] != 0 or addr[31:2] >= DEPTH.
- An invalid access writes nothing.
- It returns rdata = 0 with err = 1.
- A valid access has err = 0.
REQ-023 In RESP, only the granted port SHALL see ack = 1, with its rdata / err driven from the captured values; the other port's ack, err and rdata stay 0.
- rdata = 0 for writes.
REQ-024 Latency: a request sampled in IDLE at cycle N SHALL give memory access in cycle N+1 and ack in cycle N+2; minimum spacing between grants is 3 cycles.
REQ-025 A requester SHALL hold req until it sees ack and drop it in the next cycle; a req still high in IDLE after ack is treated as a new access.
REQ-026 A port that loses arbitration SHALL keep req high and is granted in the next IDLE cycle, so starvation is bounded to one access.
REQ-027 A request arriving while busy = 1 SHALL be ignored until IDLE, and is neither lost nor acked early.

Reset
REQ-028 When reset = 1 at a clock edge, the block SHALL do all of the following:
- state <= IDLE and last <= 1, so port 0 wins the first tie;
- clear the captured data and latched request;
- drive ack0/1, err0/1, rdata0/1, busy, mem_we, mem_addr and mem_wdata to 0 from the next cycle.
REQ-029 Reset during ACCESS or RESP SHALL abort the access with no ack; a write already strobed in ACCESS is not undone.

Verification
REQ-030 Port 0 write addr 0x08, data 0xDEADBEEF -> mem_we = 1 with mem_addr 0x08 one cycle after the request; ack0 = 1, err0 = 0 two cycles after; ack1 stays 0.
REQ-031 Port 1 read of addr 0x08 after REQ-030 -> ack1 = 1 and rdata1 = 0xDEADBEEF two cycles after the request.
REQ-032 req0 and req1 both held high from reset release -> grants alternate port 0, 1, 0, 1, with acks spaced 3 cycles apart.
REQ-033 Port 0 write to addr 0x68 (index 26), then to addr 0x05 -> each acks with err0 = 1 and rdata0 = 0, and mem_we stays 0 throughout.
REQ-034 Assert reset in the ACCESS cycle of a port 1 read -> no ack1 ever; busy = 0 next cycle; a following port 0 request completes normally.
REQ-035 req1 raised while port 0's access is in ACCESS -> port 1 is granted in the IDLE cycle after ack0 and acked 3 cycles after ack0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of the shared data memory.
// One access at a time, three cycles per grant (IDLE -> ACCESS -> RESP).
module dmem_arbiter #(
    parameter int DEPTH = 26,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [31:0]   addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [31:0]   addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          err0,
    output logic [DW-1:0] rdata0,
    output logic          ack1,
    output logic          err1,
    output logic [DW-1:0] rdata1,
    output logic          busy,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    state_t state, state_nx;

    logic          last;
    logic          any_req;
    logic          grant_id;
    logic          grant_we;
    logic [31:0]   grant_addr;
    logic [DW-1:0] grant_wdata;

    logic          lat_id;
    logic          lat_we;
    logic [31:0]   lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          lat_valid;

    logic          cap_err;
    logic [DW-1:0] cap_rdata;

    assign any_req = req0 | req1;

    // Alignment and range check on the latched address.
    assign lat_valid = (lat_addr[1:0] == 2'b00) &&
                       (lat_addr[31:2] < DEPTH_W);

    // Round-robin pick: on a tie the port that did not win last time goes.
    always_comb begin
        grant_id = 1'b0;
        if (req0 && req1) begin
            grant_id = ~last;
        end else begin
            grant_id = req1;
        end
        grant_we    = grant_id ? we1    : we0;
        grant_addr  = grant_id ? addr1  : addr0;
        grant_wdata = grant_id ? wdata1 : wdata0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ack0      = 1'b0;
        err0      = 1'b0;
        rdata0    = '0;
        ack1      = 1'b0;
        err1      = 1'b0;
        rdata1    = '0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                state_nx  = RESP;
                busy      = 1'b1;
                mem_we    = lat_we & lat_valid;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
            end
            RESP: begin
                state_nx = IDLE;
                busy     = 1'b1;
                if (lat_id) begin
                    ack1   = 1'b1;
                    err1   = cap_err;
                    rdata1 = cap_rdata;
                end else begin
                    ack0   = 1'b1;
                    err0   = cap_err;
                    rdata0 = cap_rdata;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Latch the winner's request on grant; inputs are ignored afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            last      <= 1'b1;
            lat_id    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state == IDLE && any_req) begin
            last      <= grant_id;
            lat_id    <= grant_id;
            lat_we    <= grant_we;
            lat_addr  <= grant_addr;
            lat_wdata <= grant_wdata;
        end
    end

    // Capture the memory response; writes and bad addresses return zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_err   <= 1'b0;
            cap_rdata <= '0;
        end else if (state == ACCESS) begin
            cap_err   <= ~lat_valid;
            cap_rdata <= (lat_valid && !lat_we) ? mem_rdata : '0;
        end
    end

endmodule
